// File: rtl/contact_pkg.sv
// Shared types and packet helpers for the contact result collector.
package contact_pkg;

  localparam logic [7:0]  HDR_TAG   = 8'hC5;
  localparam int unsigned PKT_WORDS = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned SEQ_W     = 16;
  localparam int unsigned IDX_W     = $clog2(PKT_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [WORD_W-1:0] cx;
    logic [WORD_W-1:0] cy;
    logic [WORD_W-1:0] cz;
    logic [WORD_W-1:0] normalx;
    logic [WORD_W-1:0] normaly;
    logic [WORD_W-1:0] normalz;
    logic [WORD_W-1:0] depth;
  } contact_t;

  // Stream word `idx` of the packet carrying contact `c` (word 0 is the header).
  function automatic logic [WORD_W-1:0] pkt_word(input contact_t c, input logic [IDX_W-1:0] idx);
    logic [WORD_W-1:0] w;
    w = '0;
    case (idx)
      3'd0:    w = {HDR_TAG, 8'h00, c.seq};
      3'd1:    w = c.cx;
      3'd2:    w = c.cy;
      3'd3:    w = c.cz;
      3'd4:    w = c.normalx;
      3'd5:    w = c.normaly;
      3'd6:    w = c.normalz;
      default: w = c.depth;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/contact_fifo.sv
// Small power-of-two FIFO of contact records; exposes the head and the entry behind it.
module contact_fifo
  import contact_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  contact_t                   wr_data,
  input  logic                       pop,
  output contact_t                   rd_data_c,
  output contact_t                   rd_nxt_c,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  contact_t           mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CW-1:0]      count_d;
  logic               do_push;
  logic               do_pop;

  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign rd_data_c = mem[rd_ptr];
  assign rd_nxt_c  = mem[rd_ptr + PTR_W'(1)];

  always_comb begin
    count_d = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
      empty <= (count_d == '0);
      full  <= (count_d == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/contact_result_collector.sv
// Captures collider contact results on the done edge, buffers them and streams 8-word packets.
module contact_result_collector
  import contact_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [31:0]      ret,
  input  logic [31:0]      cx,
  input  logic [31:0]      cy,
  input  logic [31:0]      cz,
  input  logic [31:0]      normalx,
  input  logic [31:0]      normaly,
  input  logic [31:0]      normalz,
  input  logic [31:0]      depth,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow,
  output logic             empty,
  output logic             full
);

  localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;

  logic              done_q;
  logic [CNT_W-1:0]  seq_q;
  logic              capture_c, hit_c, miss_c, push_c, drop_c;
  logic              fire_c, pop_c, remain_c, two_plus_c;
  contact_t          push_entry_c, head_c, nxt_c, follow_c;
  logic [FCNT_W-1:0] fifo_count;

  tx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_d, last_d;
  logic [31:0]       data_d;

  assign capture_c = done & ~done_q;
  assign hit_c     = capture_c & (ret != 32'd0);
  assign miss_c    = capture_c & (ret == 32'd0);
  assign push_c    = hit_c & ~full;
  assign drop_c    = hit_c & full;

  assign fire_c     = out_valid & out_ready;
  assign pop_c      = fire_c & (idx_q == LAST_IDX);
  assign two_plus_c = (fifo_count > FCNT_W'(1));
  assign remain_c   = two_plus_c | push_c;
  // With a single entry left, the follow-on packet is the one being pushed this cycle.
  assign follow_c   = two_plus_c ? nxt_c : push_entry_c;

  always_comb begin
    push_entry_c         = '0;
    push_entry_c.seq     = SEQ_W'(seq_q);
    push_entry_c.cx      = cx;
    push_entry_c.cy      = cy;
    push_entry_c.cz      = cz;
    push_entry_c.normalx = normalx;
    push_entry_c.normaly = normaly;
    push_entry_c.normalz = normalz;
    push_entry_c.depth   = depth;
  end

  contact_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .wr_data   (push_entry_c),
    .pop       (pop_c),
    .rd_data_c (head_c),
    .rd_nxt_c  (nxt_c),
    .count     (fifo_count),
    .empty     (empty),
    .full      (full)
  );

  // Transmit next-state and registered-output selection.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = out_valid;
    data_d  = out_data;
    last_d  = out_last;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SEND;
          idx_d   = '0;
          valid_d = 1'b1;
          data_d  = pkt_word(head_c, '0);
          last_d  = 1'b0;
        end
      end
      SEND: begin
        if (fire_c) begin
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            last_d = 1'b0;
            if (remain_c) begin
              data_d = pkt_word(follow_c, '0);
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
              data_d  = '0;
            end
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = pkt_word(head_c, idx_q + IDX_W'(1));
            last_d = ((idx_q + IDX_W'(1)) == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_last  <= last_d;
    end
  end

  // Edge detect, sequence number and debug statistics; clear beats any increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      seq_q    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= done;
      if (push_c) seq_q <= seq_q + CNT_W'(1);
      if (clr_stats) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_c) hit_cnt  <= hit_cnt + CNT_W'(1);
        if (miss_c) miss_cnt <= miss_cnt + CNT_W'(1);
        if (drop_c) begin
          drop_cnt <= drop_cnt + CNT_W'(1);
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_contact_result_collector.sv
// Randomized bench for contact_result_collector against a queue-based packet model.
module tb_contact_result_collector;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             done;
  logic [31:0]      ret, cx, cy, cz, normalx, normaly, normalz, depth;
  logic [31:0]      out_data;
  logic             out_valid, out_ready, out_last, clr_stats;
  logic [CNT_W-1:0] hit_cnt, miss_cnt, drop_cnt;
  logic             overflow, empty, full;

  contact_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .done(done), .ret(ret),
    .cx(cx), .cy(cy), .cz(cz),
    .normalx(normalx), .normaly(normaly), .normalz(normalz), .depth(depth),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .clr_stats(clr_stats), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: expected word stream plus contact-level occupancy.
  logic [31:0] m_words[$];
  int          m_entries;
  int          m_wpos;
  logic        m_done_q;
  logic [15:0] m_hit, m_miss, m_drop, m_seq;
  logic        m_ovf;
  logic        ne_prev, ne_now;
  logic        stall_prev, stall_last;
  logic [31:0] stall_data;
  logic [31:0] log_words[$];
  int          n_xfer;

  task automatic model_reset();
    m_words.delete();
    m_entries = 0; m_wpos = 0; m_done_q = 1'b0;
    m_hit = '0; m_miss = '0; m_drop = '0; m_seq = '0; m_ovf = 1'b0;
    ne_prev = 1'b0; ne_now = 1'b0; stall_prev = 1'b0;
  endtask

  // Called at a falling edge with inputs applied: check outputs, advance model, move one clock.
  task automatic tick();
    logic was_full, cap;
    chk("valid", out_valid, ne_prev & ne_now);
    chk("empty", empty, !ne_now);
    chk("full", full, m_entries == DEPTH);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("overflow", overflow, m_ovf);
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, stall_data);
      chk("stall_last", out_last, stall_last);
    end
    stall_prev = out_valid & ~out_ready;
    stall_data = out_data;
    stall_last = out_last;

    was_full = (m_entries == DEPTH);
    cap = done & ~m_done_q;
    if (out_valid && out_ready) begin
      n_xfer++;
      log_words.push_back(out_data);
      if (m_words.size() == 0) begin
        chk("xfer_unexpected", out_valid, 1'b0);
      end else begin
        chk("data", out_data, m_words.pop_front());
        chk("last", out_last, m_wpos == 7);
        m_wpos = (m_wpos + 1) % 8;
        if (m_wpos == 0) m_entries--;
      end
    end
    if (cap && ret != 0) begin
      if (was_full) begin
        m_drop++;
        m_ovf = 1'b1;
      end else begin
        m_words.push_back({8'hC5, 8'h00, m_seq});
        m_words.push_back(cx);      m_words.push_back(cy);      m_words.push_back(cz);
        m_words.push_back(normalx); m_words.push_back(normaly); m_words.push_back(normalz);
        m_words.push_back(depth);
        m_seq++;
        m_hit++;
        m_entries++;
      end
    end else if (cap) begin
      m_miss++;
    end
    if (clr_stats) begin
      m_hit = '0; m_miss = '0; m_drop = '0; m_ovf = 1'b0;
    end
    m_done_q = done;
    ne_prev = ne_now;
    ne_now = (m_entries > 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset applied at a falling edge; effects must be visible before any clock.
  task automatic hard_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_empty", empty, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    log_words.delete();
    n_xfer = 0;
  endtask

  task automatic rand_data();
    cx = $urandom; cy = $urandom; cz = $urandom;
    normalx = $urandom; normaly = $urandom; normalz = $urandom; depth = $urandom;
  endtask

  task automatic pulse_contact(input logic [31:0] r, input bit rnd_ready);
    rand_data();
    ret = r;
    done = 1'b1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    tick();
    done = 1'b0;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic drain(input bit rnd_ready);
    int budget;
    budget = 400;
    while (m_entries > 0 && budget > 0) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      budget--;
    end
    out_ready = 1'b1;
    tick();
    chk("drain_timeout", empty, 1'b1);
  endtask

  // Advance until word `pos` of some packet is on the bus (not ticking past it).
  task automatic wait_word(input int pos);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid && m_wpos == pos) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("wait_word_timeout", 32'(ok), 32'd1);
  endtask

  task automatic chk_header(input string tag, input int idx, input logic [15:0] seq);
    logic [31:0] w;
    if (log_words.size() > idx) begin
      w = log_words[idx];
      chk(tag, w, {8'hC5, 8'h00, seq});
    end else begin
      chk({tag, "_missing"}, 32'(log_words.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; ret = '0; out_ready = 1'b0; clr_stats = 1'b0;
    rand_data();
    model_reset();
    @(negedge clk);
    hard_reset();

    // Single contact with a free-flowing sink.
    out_ready = 1'b1;
    rand_data();
    ret = 32'd1; cx = 32'h3F800000; depth = 32'h3C6F0000;
    done = 1'b1; tick();
    done = 1'b0; tick();
    drain(1'b0);
    chk_header("t1_header", 0, 16'd0);
    if (log_words.size() >= 8) begin
      chk("t1_cx", log_words[1], 32'h3F800000);
      chk("t1_depth", log_words[7], 32'h3C6F0000);
    end else chk("t1_words", 32'(log_words.size()), 32'd8);
    chk("t1_hit", hit_cnt, 16'd1);
    chk("t1_empty", empty, 1'b1);

    // Miss held high for many cycles, then a real contact.
    hard_reset();
    out_ready = 1'b1;
    ret = 32'd0; done = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    done = 1'b0; tick();
    chk("t2_miss", miss_cnt, 16'd1);
    chk("t2_nopkt", 32'(n_xfer), 32'd0);
    pulse_contact(32'd1, 1'b0);
    drain(1'b0);
    chk_header("t2_header", 0, 16'd0);

    // Backpressure across three contacts.
    hard_reset();
    for (int i = 0; i < 3; i++) pulse_contact($urandom | 32'd1, 1'b1);
    drain(1'b1);
    chk("t3_xfers", 32'(n_xfer), 32'd24);
    chk_header("t3_hdr0", 0, 16'd0);
    chk_header("t3_hdr1", 8, 16'd1);
    chk_header("t3_hdr2", 16, 16'd2);

    // Overflow with a blocked sink.
    hard_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) pulse_contact(32'd7, 1'b0);
    chk("t4_full", full, 1'b1);
    chk("t4_drop", drop_cnt, 16'd2);
    chk("t4_ovf", overflow, 1'b1);
    drain(1'b0);
    chk("t4_xfers", 32'(n_xfer), 32'd32);
    for (int i = 0; i < 4; i++) chk_header("t4_hdr", i * 8, 16'(i));

    // Capture coinciding with a word-7 pop while full: dropped.
    hard_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse_contact(32'd3, 1'b0);
    out_ready = 1'b1;
    wait_word(7);
    rand_data(); ret = 32'd5; done = 1'b1; tick();
    done = 1'b0; tick();
    chk("t5_drop", drop_cnt, 16'd1);
    drain(1'b0);
    chk("t5_xfers", 32'(n_xfer), 32'd32);

    // Capture coinciding with a word-7 pop at two entries: stored.
    hard_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) pulse_contact(32'd3, 1'b0);
    out_ready = 1'b1;
    wait_word(7);
    rand_data(); ret = 32'd5; done = 1'b1; tick();
    done = 1'b0;
    chk("t5b_hit", hit_cnt, 16'd3);
    chk("t5b_drop", drop_cnt, 16'd0);
    drain(1'b0);
    chk("t5b_xfers", 32'(n_xfer), 32'd24);

    // Reset in the middle of a packet.
    hard_reset();
    out_ready = 1'b1;
    pulse_contact(32'd1, 1'b0);
    pulse_contact(32'd1, 1'b0);
    wait_word(3);
    hard_reset();
    pulse_contact(32'd1, 1'b0);
    drain(1'b0);
    chk_header("t6_hdr", 0, 16'd0);
    chk("t6_xfers", 32'(n_xfer), 32'd8);

    // Statistics clear leaves the FIFO and sequence intact.
    hard_reset();
    out_ready = 1'b0;
    pulse_contact(32'd1, 1'b0);
    pulse_contact(32'd0, 1'b0);
    pulse_contact(32'd1, 1'b0);
    clr_stats = 1'b1; tick();
    clr_stats = 1'b0;
    chk("t6_clr_hit", hit_cnt, 16'd0);
    chk("t6_clr_miss", miss_cnt, 16'd0);
    chk("t6_clr_empty", empty, 1'b0);
    pulse_contact(32'd1, 1'b0);
    drain(1'b0);
    chk("t6_clr_xfers", 32'(n_xfer), 32'd24);
    chk_header("t6_clr_hdr2", 16, 16'd2);

    // Random traffic.
    hard_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      done = ($urandom_range(0, 2) == 0);
      ret = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'd1);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 63) == 0);
      tick();
    end
    done = 1'b0; clr_stats = 1'b0;
    drain(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
